// File: rtl/filter_pkg.sv
// Shared types and default geometry for the frame-synchronous filter kernel controller.
package filter_pkg;

  localparam int H_ACTIVE_DFLT    = 320;
  localparam int V_ACTIVE_DFLT    = 240;
  localparam int NUM_KERNELS_DFLT = 6;
  localparam int DEFAULT_K_DFLT   = 0;

  typedef logic [2:0] kernel_id_t;

  typedef enum logic {IDLE, RUN} filter_ctrl_state_t;

endpackage

// File: rtl/kernel_tag_fifo.sv
// Two-entry FIFO of kernel IDs that carries each committed kernel across the line-buffer lag.
// Push is ignored when full unless a pop frees the slot in the same cycle; pop is ignored when empty.
module kernel_tag_fifo
  import filter_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push_in,
  input  logic       pop_in,
  input  kernel_id_t data_in,
  output kernel_id_t head_out,
  output logic       full_out,
  output logic       empty_out
);

  kernel_id_t mem_q [2];
  kernel_id_t mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // When full, push and pop share one slot; the head is read from mem_q before it is overwritten.
  always_comb begin
    do_pop   = pop_in && (count_q != 2'd0);
    do_push  = push_in && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_out  = mem_q[rd_ptr_q];
  assign full_out  = (count_q == 2'd2);
  assign empty_out = (count_q == 2'd0);

endmodule

// File: rtl/filter_kernel_ctrl.sv
// Commits kernel-change requests at input frame start and tags output frames with their kernel.
// Define FILTER_CTRL_BORDER_MASK_EN to generate the registered output border mask.
module filter_kernel_ctrl
  import filter_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DFLT,
  parameter int V_ACTIVE    = V_ACTIVE_DFLT,
  parameter int NUM_KERNELS = NUM_KERNELS_DFLT,
  parameter int DEFAULT_K   = DEFAULT_K_DFLT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [2:0]  kernel_req_in,
  input  logic        kernel_req_valid_in,
  input  logic        in_valid_in,
  input  logic [10:0] in_hcount_in,
  input  logic [9:0]  in_vcount_in,
  input  logic        out_valid_in,
  input  logic [10:0] out_hcount_in,
  input  logic [9:0]  out_vcount_in,
  output logic [2:0]  kernel_sel_out,
  output logic [2:0]  kernel_tag_out,
  output logic        switch_out,
  output logic [15:0] frame_count_out,
  output logic        req_err_out,
  output logic        tag_err_out,
  output logic        border_mask_out
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam kernel_id_t  DEF_ID = kernel_id_t'(DEFAULT_K);

  filter_ctrl_state_t state_q, state_d;
  kernel_id_t         pending_q, pending_d;
  kernel_id_t         sel_q, sel_d;
  kernel_id_t         tag_q, tag_d;
  logic               switch_q, switch_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               req_err_q, req_err_d;
  logic               tag_err_q, tag_err_d;

  logic       in_sof, in_eof, out_sof, req_ok;
  kernel_id_t fifo_head;
  logic       fifo_full, fifo_empty;

  assign in_sof  = in_valid_in && (in_hcount_in == 11'd0) && (in_vcount_in == 10'd0);
  assign in_eof  = in_valid_in && (in_hcount_in == H_LAST) && (in_vcount_in == V_LAST);
  assign out_sof = out_valid_in && (out_hcount_in == 11'd0) && (out_vcount_in == 10'd0);
  assign req_ok  = kernel_req_valid_in && ({29'd0, kernel_req_in} < 32'(NUM_KERNELS));

  kernel_tag_fifo u_tag_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (in_sof),
    .pop_in    (out_sof),
    .data_in   (pending_q),
    .head_out  (fifo_head),
    .full_out  (fifo_full),
    .empty_out (fifo_empty)
  );

  // Commit uses the registered pending, so a request coinciding with in_sof waits a frame.
  always_comb begin
    state_d     = state_q;
    pending_d   = req_ok ? kernel_req_in : pending_q;
    sel_d       = sel_q;
    tag_d       = tag_q;
    switch_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    req_err_d   = kernel_req_valid_in && !req_ok;
    tag_err_d   = tag_err_q;
    if (in_sof) begin
      state_d  = RUN;
      sel_d    = pending_q;
      switch_d = (pending_q != sel_q);
    end
    if (in_eof && (state_q == RUN)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (out_sof && !fifo_empty) begin
      tag_d = fifo_head;
    end
    if ((in_sof && fifo_full && !out_sof) || (out_sof && fifo_empty)) begin
      tag_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pending_q   <= DEF_ID;
      sel_q       <= DEF_ID;
      tag_q       <= DEF_ID;
      switch_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
      req_err_q   <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      sel_q       <= sel_d;
      tag_q       <= tag_d;
      switch_q    <= switch_d;
      frame_cnt_q <= frame_cnt_d;
      req_err_q   <= req_err_d;
      tag_err_q   <= tag_err_d;
    end
  end

  assign kernel_sel_out  = sel_q;
  assign kernel_tag_out  = tag_q;
  assign switch_out      = switch_q;
  assign frame_count_out = frame_cnt_q;
  assign req_err_out     = req_err_q;
  assign tag_err_out     = tag_err_q;

`ifdef FILTER_CTRL_BORDER_MASK_EN
  logic border_q, border_d;

  // Flags output pixels whose kernel window straddles the frame edge.
  always_comb begin
    border_d = out_valid_in && ((out_hcount_in == 11'd0) || (out_hcount_in == H_LAST) ||
                                (out_vcount_in == 10'd0) || (out_vcount_in == V_LAST));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      border_q <= 1'b0;
    end else begin
      border_q <= border_d;
    end
  end

  assign border_mask_out = border_q;
`else
  assign border_mask_out = 1'b0;
`endif

endmodule
